// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
//
// Single-neuron multiply-accumulate stage. Streams NUMWEIGHT signed fixed-point
// activations, reads the matching weight from an attached registered
// weight_memory, accumulates the products, adds BIAS, then emits one saturated
// DATAWIDTH-bit result per vector.
//
// Optional feature macro: NEURON_RELU_EN
//   defined   -> ReLU applied after saturation (hidden layers)
//   undefined -> linear output (final layer)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data valid this cycle
//   in_data    in   signed activation, DATAWIDTH bits
//   in_ready   out  block accepts in_data this cycle
//   ren        out  weight_memory read enable (same cycle as accept)
//   radd       out  weight_memory read address (index of the next input)
//   win        in   weight_memory output, valid one cycle after ren
//   out_valid  out  one-cycle result pulse
//   out_data   out  signed neuron result, held until the next result
// -----------------------------------------------------------------------------
module neuron_mac #(
  parameter int                          NUMWEIGHT    = 784,
  parameter int                          ADDRESSWIDTH = $clog2(NUMWEIGHT),
  parameter int                          DATAWIDTH    = 16,
  parameter int                          FRACBITS     = 8,
  parameter logic signed [DATAWIDTH-1:0] BIAS         = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic signed [DATAWIDTH-1:0]    in_data,
  output logic                           in_ready,
  output logic                           ren,
  output logic        [ADDRESSWIDTH-1:0] radd,
  input  logic signed [DATAWIDTH-1:0]    win,
  output logic                           out_valid,
  output logic signed [DATAWIDTH-1:0]    out_data
);

  localparam int PRODW = 2 * DATAWIDTH;
  // Headroom for NUMWEIGHT full-scale products, so the accumulator never wraps.
  localparam int ACCW  = PRODW + ADDRESSWIDTH;
  // One extra bit so adding the bias cannot wrap either.
  localparam int SUMW  = ACCW + 1;

  localparam logic [ADDRESSWIDTH-1:0] LAST_IDX = ADDRESSWIDTH'(NUMWEIGHT - 1);
  localparam logic signed [SUMW-1:0]  MAX_V    = SUMW'((2 ** (DATAWIDTH - 1)) - 1);
  localparam logic signed [SUMW-1:0]  MIN_V    = -MAX_V - SUMW'(1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic                           w_accept;
  logic                           w_last_accept;
  logic        [ADDRESSWIDTH-1:0] r_count;

  logic signed [DATAWIDTH-1:0]    r_x_p1;
  logic                           r_vld_p1;
  logic                           r_last_p1;
  logic signed [PRODW-1:0]        r_prod_p2;
  logic                           r_vld_p2;
  logic                           r_last_p2;
  logic signed [ACCW-1:0]         r_acc_p3;

  logic signed [SUMW-1:0]         w_sum;
  logic signed [SUMW-1:0]         w_shift;
  logic signed [DATAWIDTH-1:0]    w_result;

  // Clamp the shifted sum into the DATAWIDTH signed range.
  function automatic logic signed [DATAWIDTH-1:0] saturate(
    input logic signed [SUMW-1:0] v
  );
    logic signed [SUMW-1:0] c;
    if (v > MAX_V)      c = MAX_V;
    else if (v < MIN_V) c = MIN_V;
    else                c = v;
    return c[DATAWIDTH-1:0];
  endfunction

  function automatic logic signed [DATAWIDTH-1:0] activate(
    input logic signed [DATAWIDTH-1:0] v
  );
`ifdef NEURON_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign w_accept      = in_valid && in_ready;
  assign w_last_accept = w_accept && (r_count == LAST_IDX);
  assign ren           = w_accept;
  assign radd          = r_count;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    unique case (r_state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (w_last_accept) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The final product lands in the accumulator on this edge.
        if (r_vld_p2 && r_last_p2) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p1: capture activation alongside the weight read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= w_accept;
      r_last_p1 <= w_last_accept;
      if (w_accept) r_count <= w_last_accept ? '0 : r_count + ADDRESSWIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_x_p1 <= in_data;
  end

  // ---------------------------------------------------------------------------
  // Stage p2: full-precision product with the registered weight
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_last_p2 <= 1'b0;
    end else begin
      r_vld_p2  <= r_vld_p1;
      r_last_p2 <= r_last_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_vld_p1) r_prod_p2 <= r_x_p1 * win;
  end

  // ---------------------------------------------------------------------------
  // Stage p3: accumulate; cleared when the result is emitted
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_acc_p3 <= '0;
    else if (r_state == ST_EMIT) r_acc_p3 <= '0;
    else if (r_vld_p2)         r_acc_p3 <= r_acc_p3 + ACCW'(r_prod_p2);
  end

  // ---------------------------------------------------------------------------
  // Output stage: bias, rescale (floor), saturate, activate
  // ---------------------------------------------------------------------------
  assign w_sum    = SUMW'(r_acc_p3) + (SUMW'(BIAS) <<< FRACBITS);
  assign w_shift  = w_sum >>> FRACBITS;
  assign w_result = activate(saturate(w_shift));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= (r_state == ST_EMIT);
      if (r_state == ST_EMIT) out_data <= w_result;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac
//
// Bench for neuron_mac with NUMWEIGHT=4, DATAWIDTH=16, FRACBITS=8, BIAS=0 and a
// registered weight ROM of {1.0, 2.0, -1.0, 0.5}. Accepted activations are
// collected into vectors; each complete vector's expected result (dot product,
// floor rescale, saturation, optional ReLU) is queued with its due cycle and a
// monitor pops and compares whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_neuron_mac;

  localparam int NW   = 4;
  localparam int AW   = 2;
  localparam int DW   = 16;
  localparam int FB   = 8;
  localparam int BIAS = 0;
  localparam int WTS [NW] = '{256, 512, -256, 128};

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 ren;
  logic        [AW-1:0] radd;
  logic signed [DW-1:0] win = '0;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;

  neuron_mac #(
    .NUMWEIGHT   (NW),
    .ADDRESSWIDTH(AW),
    .DATAWIDTH   (DW),
    .FRACBITS    (FB),
    .BIAS        (16'(BIAS))
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ren      (ren),
    .radd     (radd),
    .win      (win),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  // Registered weight memory
  always @(posedge clk) if (ren) win <= 16'(WTS[radd]);

  typedef struct {
    longint data;
    longint cyc;
  } exp_t;

  exp_t   sbq[$];
  int     vec[$];
  int     exp_idx = 0;
  longint cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: real-number neuron evaluated with wide integer arithmetic.
  function automatic longint ref_neuron(input int xs[$]);
    longint sum = 0;
    longint s;
    for (int i = 0; i < NW; i++) sum += longint'(xs[i]) * longint'(WTS[i]);
    sum += longint'(BIAS) * (longint'(1) << FB);
    s = sum >>> FB;                    // floor division by 2^FB
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`ifdef NEURON_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Accept tracker, read-port checks and result monitor (mid-cycle sampling)
  always @(negedge clk) begin
    if (!rst_n) begin
      vec.delete();
      exp_idx = 0;
    end else begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("out_data", longint'(out_data), e.data);
          check("out_latency_cycle", cyc, e.cyc);
        end
      end
      check("ren_eq_accept", longint'(ren), longint'(in_valid && in_ready));
      if (in_valid && in_ready) begin
        exp_t e;
        check("radd", longint'(radd), longint'(exp_idx));
        vec.push_back(int'(in_data));
        exp_idx = (exp_idx + 1) % NW;
        if (vec.size() == NW) begin
          e.data = ref_neuron(vec);
          e.cyc  = cyc + 4;
          sbq.push_back(e);
          vec.delete();
        end
      end
    end
  end

  task automatic drive_one(input int x);
    int n = 0;
    bit got = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'(x);
    while (!got) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (!got) begin
        n++;
        if (n > 100) begin
          check("accept_timeout", n, 0);
          got = 1'b1;
        end
      end
    end
  endtask

  task automatic drive_vec(input int xs[NW], input bit gaps);
    for (int i = 0; i < NW; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      drive_one(xs[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(posedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int v[NW];
    int lo;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_ren", ren, 0);
    check("rst_radd", radd, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unit inputs, continuous
    v = '{256, 256, 256, 256};
    drive_vec(v, 1'b0);
    // Negative sum (ReLU-dependent)
    v = '{0, 0, 256, 0};
    drive_vec(v, 1'b0);
    // Positive saturation
    v = '{32767, 32767, 32767, 32767};
    drive_vec(v, 1'b0);

    // Toggling in_valid, then in_valid held high through the drain
    v = '{256, 256, 256, 256};
    drive_vec(v, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'(999);
    lo = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready) begin
        check("ready_return_with_out_valid", out_valid, 1);
        break;
      end
      lo++;
      check("drain_radd", radd, 0);
      check("drain_ren", ren, 0);
    end
    check("in_ready_low_cycles", lo, 3);
    @(posedge clk);
    #1;
    drive_one(-300);
    drive_one(1000);
    drive_one(-32768);
    in_valid = 1'b0;

    // Randomized back-to-back vectors
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NW; i++)
        v[i] = (n % 2 == 0) ? int'($urandom_range(0, 2047)) - 1024
                            : int'(16'($urandom_range(0, 65535))) - ((int'(16'($urandom_range(0, 1))) << 16));
      for (int i = 0; i < NW; i++) v[i] = int'($signed(16'(v[i])));
      drive_vec(v, n == 5);
    end
    wait_idle();

    // Reset in the middle of a vector
    drive_one(256);
    drive_one(256);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_radd", radd, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = '{256, 256, 256, 256};
    drive_vec(v, 1'b0);
    wait_idle();
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Single-neuron multiply-accumulate stage that sits directly downstream of `weight_memory` and drives its read port. It accepts a stream of NUMWEIGHT signed fixed-point activations and fetches the matching weight for each one. It accumulates the products, adds a bias, then emits one saturated DATAWIDTH-bit neuron output per input vector. One instance is used per neuron in a layer.

## Interface
- NUMWEIGHT, 784, inputs per vector; also the depth of the attached weight_memory.
- ADDRESSWIDTH, $clog2(NUMWEIGHT), width of the weight read address.
- DATAWIDTH, 16, width of activations, weights, bias and output; all are signed two's complement.
- FRACBITS, 8, fractional bits shared by activations, weights, bias and output.
- BIAS, 0, signed DATAWIDTH bias in the same Q format.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  DATAWIDTH  signed activation.
- in_ready  out  1  block accepts in_data this cycle.
- ren  out  1  weight_memory read enable.
- radd  out  ADDRESSWIDTH  weight_memory read address.
- win  in  DATAWIDTH  weight_memory output; registered, valid one cycle after ren.
- out_valid  out  1  one-cycle pulse; out_data is valid.
- out_data  out  DATAWIDTH  signed neuron result.

## Operation
- Accept: an accept occurs when in_valid && in_ready.
- Read-port drive:
  - ren = accept, combinational.
  - radd = count, the registered index of the next input, from 0 to NUMWEIGHT-1.
- Pipeline, with accept in cycle t:
  - edge t: weight_memory registers win. The block registers x1 = in_data, v1 = 1, last1 = (count == NUMWEIGHT-1). count increments, or wraps to 0 if last.
  - edge t+1: p = x1 * win, signed full 2*DATAWIDTH product; v2 and last2 are registered.
  - edge t+2: acc <= acc + p when v2. The accumulator is 2*DATAWIDTH+ADDRESSWIDTH bits, sign-extended, and cannot overflow.
  - edge t+3, only when last2 was accumulated: s = (acc + (BIAS <<< FRACBITS)) >>> FRACBITS, arithmetic shift, truncate toward minus infinity. s saturates to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1] and passes the activation stage (see Configuration). The result goes to out_data, out_valid = 1, and acc clears to 0.
- FSM:
  - ACCUM: in_ready = 1. An accept with count == NUMWEIGHT-1 moves to DRAIN.
  - DRAIN: in_ready = 0. Waits for the final accumulation, then moves to EMIT.
  - EMIT: in_ready = 0. out_valid pulses this edge; next state is ACCUM.
- in_valid gaps are allowed at any point. Bubbles propagate with v1 = 0 and v2 = 0 and do not change acc.
- in_valid high while in_ready is low: the input is ignored, with no read and no count change.
- out_data holds its value after the pulse until the next result.

## Timing
- Reset values, asynchronous and immediate: in_ready = 1 (state ACCUM), ren = 0, radd = 0, out_valid = 0, out_data = 0. acc, count, v1, v2, last1 and last2 are all 0.
- Latency: out_valid rises 4 cycles after the cycle of the last accept. That is the cycle following edge t+3.
- Back-to-back throughput: NUMWEIGHT + 3 cycles per vector. in_ready is low for the 3 cycles between the last accept and re-entering ACCUM.
- in_ready returns to 1 in the same cycle that out_valid is high. A new vector's first accept can coincide with the out_valid cycle.
- Reset mid-vector discards the partial sum and restarts at radd = 0. No out_valid is produced for the aborted vector.

## Configuration
- NEURON_RELU_EN defined: out_data = (s < 0) ? 0 : s, applied after saturation.
- NEURON_RELU_EN undefined: out_data = s, a linear output used for the final layer.

## Test plan
All scenarios use NUMWEIGHT=4, DATAWIDTH=16, FRACBITS=8, BIAS=0, with weights {256, 512, -256, 128} = {1.0, 2.0, -1.0, 0.5}.
- Inputs 256, 256, 256, 256, continuous -> radd 0,1,2,3 with ren high for 4 cycles; out_data = 640 (2.5); out_valid 4 cycles after the last accept.
- Inputs 0, 0, 256, 0 -> s = -256. With NEURON_RELU_EN: out_data = 0. Without it: out_data = -256 (0xFF00).
- Inputs 32767 ×4 -> pre-saturation sum ≈ 80k -> out_data = 32767 (saturated).
- in_valid toggling 1,0,1,0,... with inputs 256 ×4 -> same result of 640; in_ready low for exactly 3 cycles after the last accept; in_valid held high during DRAIN is ignored, with radd staying at 0.
- Two vectors back-to-back: the second vector's first accept happens in the out_valid cycle -> two results with correct independent sums; acc is not carried over.
- rst_n asserted after 2 accepts, then a full vector of 256 ×4 -> no spurious out_valid; result is 640; radd restarts at 0.
